ct_ibiu_csr_req: RTL and testbench

Core-side initiator for L2/CIU control-register accesses. It takes single CSR operations from the core CP0 unit, sends them to the CIU over the `ibiu_ciu_csr_*` request channel, and waits for `ciu_ibiu_csr_cmplt`. It then returns the 128-bit read data to CP0. It sits in the IBIU and is the requesting end of the PIU CSR path.

---
 rtl/ct_ibiu_csr_req_pkg.sv | 31 +++
 rtl/ct_ibiu_csr_timer.sv | 27 ++
 rtl/ct_ibiu_csr_req.sv | 129 ++++++++++++
 tb/tb_ct_ibiu_csr_req.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ct_ibiu_csr_req_pkg.sv
// Shared definitions for the IBIU CSR request path: FSM encodings, field widths and payload layout.
// Optional response timeout is enabled by defining CT_IBIU_CSR_TIMEOUT_EN.
package ct_ibiu_csr_req_pkg;

  localparam int CSR_OP_W      = 16;
  localparam int CSR_WDATA_W   = 64;
  localparam int CSR_RDATA_W   = 128;
  localparam int CSR_PAYLOAD_W = CSR_OP_W + CSR_WDATA_W;

  localparam int PAYLOAD_OP_MSB   = 79;
  localparam int PAYLOAD_OP_LSB   = 64;
  localparam int PAYLOAD_DATA_MSB = 63;
  localparam int PAYLOAD_DATA_LSB = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  function automatic logic [CSR_PAYLOAD_W-1:0] csr_pack(
    input logic [CSR_OP_W-1:0]    op,
    input logic [CSR_WDATA_W-1:0] wdata
  );
    logic [CSR_PAYLOAD_W-1:0] p;
    p = '0;
    p[PAYLOAD_OP_MSB:PAYLOAD_OP_LSB]     = op;
    p[PAYLOAD_DATA_MSB:PAYLOAD_DATA_LSB] = wdata;
    return p;
  endfunction

endpackage

// File: rtl/ct_ibiu_csr_timer.sv
// Response-timeout counter: synchronous clear, increment, and all-ones terminal-count flag.
// Only instantiated when CT_IBIU_CSR_TIMEOUT_EN is defined.
module ct_ibiu_csr_timer #(
  parameter int TIMEOUT_W = 10
) (
  input  logic forever_cpuclk,
  input  logic cpurst_b,
  input  logic clr,
  input  logic inc,
  output logic term
);

  logic [TIMEOUT_W-1:0] cnt_reg;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign term = &cnt_reg;

endmodule

// File: rtl/ct_ibiu_csr_req.sv
// CP0-to-CIU CSR request initiator: one outstanding operation, registered outputs throughout.
// Define CT_IBIU_CSR_TIMEOUT_EN to add the response timeout and drive biu_cp0_err.
module ct_ibiu_csr_req
  import ct_ibiu_csr_req_pkg::*;
#(
  parameter int TIMEOUT_W = 10
) (
  input  logic                     forever_cpuclk,
  input  logic                     cpurst_b,
  input  logic                     cp0_biu_sel,
  input  logic [CSR_OP_W-1:0]      cp0_biu_op,
  input  logic [CSR_WDATA_W-1:0]   cp0_biu_wdata,
  output logic                     biu_cp0_busy,
  output logic                     biu_cp0_cmplt,
  output logic [CSR_RDATA_W-1:0]   biu_cp0_rdata,
  output logic                     biu_cp0_err,
  output logic                     ibiu_ciu_csr_sel,
  output logic [CSR_PAYLOAD_W-1:0] ibiu_ciu_csr_wdata,
  input  logic                     ciu_ibiu_csr_cmplt,
  input  logic [CSR_RDATA_W-1:0]   ciu_ibiu_csr_rdata
);

  logic [1:0]               state_reg;
  logic [1:0]               state_next;
  logic                     accept;
  logic                     resp_take;
  logic                     timeout_hit;
  logic                     timeout_fire;
  logic [CSR_PAYLOAD_W-1:0] payload_reg;
  logic [CSR_RDATA_W-1:0]   rdata_reg;
  logic                     csr_sel_reg;
  logic                     busy_reg;
  logic                     cmplt_reg;

`ifdef CT_IBIU_CSR_TIMEOUT_EN
  logic err_reg;

  ct_ibiu_csr_timer #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_timer (
    .forever_cpuclk (forever_cpuclk),
    .cpurst_b       (cpurst_b),
    .clr            (accept),
    .inc            ((state_reg == ST_REQ) || (state_reg == ST_WAIT)),
    .term           (timeout_hit)
  );

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      err_reg <= 1'b0;
    end else if (accept) begin
      err_reg <= 1'b0;
    end else if (timeout_fire) begin
      err_reg <= 1'b1;
    end
  end

  assign biu_cp0_err = err_reg;
`else
  assign timeout_hit = 1'b0;
  assign biu_cp0_err = 1'b0;
`endif

  // A CIU response always beats a timeout landing in the same cycle.
  always_comb begin
    state_next   = state_reg;
    accept       = 1'b0;
    resp_take    = 1'b0;
    timeout_fire = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cp0_biu_sel) begin
          accept     = 1'b1;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ciu_ibiu_csr_cmplt) begin
          resp_take  = 1'b1;
          state_next = ST_RESP;
        end else begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ciu_ibiu_csr_cmplt) begin
          resp_take  = 1'b1;
          state_next = ST_RESP;
        end else if (timeout_hit) begin
          timeout_fire = 1'b1;
          state_next   = ST_RESP;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_reg   <= ST_IDLE;
      payload_reg <= '0;
      rdata_reg   <= '0;
      csr_sel_reg <= 1'b0;
      busy_reg    <= 1'b0;
      cmplt_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      csr_sel_reg <= accept;
      busy_reg    <= (state_next != ST_IDLE);
      cmplt_reg   <= (state_next == ST_RESP);
      if (accept) begin
        payload_reg <= csr_pack(cp0_biu_op, cp0_biu_wdata);
      end
      if (resp_take) begin
        rdata_reg <= ciu_ibiu_csr_rdata;
      end else if (timeout_fire) begin
        rdata_reg <= '0;
      end
    end
  end

  assign biu_cp0_busy       = busy_reg;
  assign biu_cp0_cmplt      = cmplt_reg;
  assign biu_cp0_rdata      = rdata_reg;
  assign ibiu_ciu_csr_sel   = csr_sel_reg;
  assign ibiu_ciu_csr_wdata = payload_reg;

endmodule

// File: tb/tb_ct_ibiu_csr_req.sv
// Scoreboard bench for ct_ibiu_csr_req; timeout cases run when CT_IBIU_CSR_TIMEOUT_EN is defined.
module tb_ct_ibiu_csr_req;

  localparam int TW = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cp0_biu_sel = 1'b0;
  logic [15:0]  cp0_biu_op = '0;
  logic [63:0]  cp0_biu_wdata = '0;
  logic         biu_cp0_busy;
  logic         biu_cp0_cmplt;
  logic [127:0] biu_cp0_rdata;
  logic         biu_cp0_err;
  logic         ibiu_ciu_csr_sel;
  logic [79:0]  ibiu_ciu_csr_wdata;
  logic         ciu_cmplt = 1'b0;
  logic [127:0] ciu_rdata = '0;

  always #5 clk = ~clk;

  ct_ibiu_csr_req #(.TIMEOUT_W(TW)) dut (
    .forever_cpuclk     (clk),
    .cpurst_b           (rst_n),
    .cp0_biu_sel        (cp0_biu_sel),
    .cp0_biu_op         (cp0_biu_op),
    .cp0_biu_wdata      (cp0_biu_wdata),
    .biu_cp0_busy       (biu_cp0_busy),
    .biu_cp0_cmplt      (biu_cp0_cmplt),
    .biu_cp0_rdata      (biu_cp0_rdata),
    .biu_cp0_err        (biu_cp0_err),
    .ibiu_ciu_csr_sel   (ibiu_ciu_csr_sel),
    .ibiu_ciu_csr_wdata (ibiu_ciu_csr_wdata),
    .ciu_ibiu_csr_cmplt (ciu_cmplt),
    .ciu_ibiu_csr_rdata (ciu_rdata)
  );

  typedef struct {
    logic [127:0] rdata;
    logic         err;
    int           cyc;
  } exp_t;

  exp_t         sb_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           sel_seen = 0;
  logic [127:0] last_rd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every completion must match the oldest expected response, including its cycle.
  always @(negedge clk) begin
    exp_t e;
    if (ibiu_ciu_csr_sel) sel_seen++;
    if (biu_cp0_cmplt) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cmplt rdata=%h cycle=%0d want=no completion", biu_cp0_rdata, cyc);
      end else begin
        e = sb_q.pop_front();
        chk("cmplt_cycle", 128'(cyc), 128'(e.cyc));
        chk("cmplt_rdata", biu_cp0_rdata, e.rdata);
        chk("cmplt_err", {127'd0, biu_cp0_err}, {127'd0, e.err});
        $display("cmplt cycle=%0d rdata=%h err=%0d", cyc, biu_cp0_rdata, biu_cp0_err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, {127'd0, biu_cp0_busy}, 128'd0);
    chk({tag, "_cmplt"}, {127'd0, biu_cp0_cmplt}, 128'd0);
    chk({tag, "_err"}, {127'd0, biu_cp0_err}, 128'd0);
    chk({tag, "_sel"}, {127'd0, ibiu_ciu_csr_sel}, 128'd0);
    chk({tag, "_wdata"}, {48'd0, ibiu_ciu_csr_wdata}, 128'd0);
    chk({tag, "_rdata"}, biu_cp0_rdata, 128'd0);
  endtask

  // One CSR operation; the CIU answers dly cycles after the sel cycle (0 = same cycle).
  task automatic do_op(input logic [15:0] op, input logic [63:0] wd, input int dly,
                       input logic [127:0] rd, input bit poke);
    int   sel0;
    exp_t e;
    sel0          = sel_seen;
    cp0_biu_sel   = 1'b1;
    cp0_biu_op    = op;
    cp0_biu_wdata = wd;
    tick();
    cp0_biu_sel   = 1'b0;
    cp0_biu_op    = 16'($urandom);
    cp0_biu_wdata = {$urandom, $urandom};
    chk("req_sel", {127'd0, ibiu_ciu_csr_sel}, 128'd1);
    chk("req_busy", {127'd0, biu_cp0_busy}, 128'd1);
    chk("req_wdata", {48'd0, ibiu_ciu_csr_wdata}, {48'd0, op, wd});
    for (int i = 0; i < dly; i++) begin
      tick();
      cp0_biu_sel = poke && (i == 0);
      if (poke && i == 0) cp0_biu_op = 16'h0034;
      chk("wait_sel", {127'd0, ibiu_ciu_csr_sel}, 128'd0);
      chk("wait_wdata", {48'd0, ibiu_ciu_csr_wdata}, {48'd0, op, wd});
    end
    ciu_cmplt = 1'b1;
    ciu_rdata = rd;
    e.rdata = rd;
    e.err   = 1'b0;
    e.cyc   = cyc + 1;
    sb_q.push_back(e);
    tick();
    cp0_biu_sel = 1'b0;
    ciu_cmplt   = 1'b0;
    ciu_rdata   = {$urandom, $urandom, $urandom, $urandom};
    chk("resp_wdata", {48'd0, ibiu_ciu_csr_wdata}, {48'd0, op, wd});
    tick();
    chk("done_busy", {127'd0, biu_cp0_busy}, 128'd0);
    chk("sel_pulses", 128'(sel_seen - sel0), 128'd1);
    chk("rdata_hold", biu_cp0_rdata, rd);
    last_rd = rd;
    $display("op op=%h wdata=%h dly=%0d poke=%0d", op, wd, dly, poke);
  endtask

  task automatic stray();
    ciu_cmplt = 1'b1;
    ciu_rdata = '1;
    tick();
    ciu_cmplt = 1'b0;
    tick();
    tick();
    chk("stray_rdata", biu_cp0_rdata, last_rd);
    chk("stray_busy", {127'd0, biu_cp0_busy}, 128'd0);
    $display("stray response in idle, rdata=%h", biu_cp0_rdata);
  endtask

`ifdef CT_IBIU_CSR_TIMEOUT_EN
  // No response (or a response exactly on the terminal WAIT cycle) after 2^TW-1 WAIT cycles.
  task automatic tmo_op(input bit hit_term, input logic [127:0] rd);
    exp_t e;
    cp0_biu_sel   = 1'b1;
    cp0_biu_op    = 16'h00AB;
    cp0_biu_wdata = 64'h1;
    tick();
    cp0_biu_sel = 1'b0;
    e.rdata = hit_term ? rd : 128'd0;
    e.err   = !hit_term;
    e.cyc   = cyc + (1 << TW);
    sb_q.push_back(e);
    for (int i = 1; i < (1 << TW); i++) begin
      tick();
      if (hit_term && i == (1 << TW) - 1) begin
        ciu_cmplt = 1'b1;
        ciu_rdata = rd;
      end
    end
    tick();
    ciu_cmplt = 1'b0;
    tick();
    chk("tmo_busy", {127'd0, biu_cp0_busy}, 128'd0);
    last_rd = e.rdata;
    $display("timeout op hit_term=%0d", hit_term);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk_all_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    do_op(16'h0012, 64'h0, 3, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A50001, 1'b1);
    do_op(16'h0056, 64'hDEAD_BEEF_0000_1111, 0, 128'h1234, 1'b0);
    stray();

    for (int n = 0; n < 40; n++) begin
      do_op(16'($urandom), {$urandom, $urandom}, int'($urandom_range(0, 4)),
            {$urandom, $urandom, $urandom, $urandom}, bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 7) == 0) stray();
    end

    // Reset in the middle of WAIT: the aborted operation must never complete.
    cp0_biu_sel   = 1'b1;
    cp0_biu_op    = 16'h0077;
    cp0_biu_wdata = 64'h77;
    tick();
    cp0_biu_sel = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    tick();
    tick();
    rst_n = 1'b1;
    last_rd = '0;
    stray();
    do_op(16'h0099, 64'h5555_AAAA_5555_AAAA, 2, 128'hCAFE_F00D, 1'b0);

`ifdef CT_IBIU_CSR_TIMEOUT_EN
    tmo_op(1'b0, 128'd0);
    do_op(16'h0012, 64'h2, 1, 128'h77, 1'b0);
    tmo_op(1'b1, 128'hBEEF_0000_0000_0001);
`endif

    repeat (3) tick();
    chk("sb_empty", 128'(sb_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
